// File: rtl/bcd_convert_sched_if.sv
// Request/grant and result bundle between the two score sources, the shared
// binary-to-BCD converter and the seven-segment display logic.
interface bcd_convert_sched_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             req0;
  logic [WIDTH-1:0] bin0;
  logic             ack0;
  logic             req1;
  logic [WIDTH-1:0] bin1;
  logic             ack1;
  logic             busy;
  logic             done;
  logic             done_id;
  logic [3:0]       digit0;
  logic [3:0]       digit1;
  logic [3:0]       digit2;

  modport master (
    output req0, bin0, req1, bin1,
    input  ack0, ack1, busy, done, done_id, digit0, digit1, digit2
  );

  modport slave (
    input  req0, bin0, req1, bin1,
    output ack0, ack1, busy, done, done_id, digit0, digit1, digit2
  );
endinterface

// File: rtl/bcd_convert_sched.sv
// Iterative double-dabble binary-to-BCD converter shared by two requesters
// through a round-robin arbiter; one conversion every WIDTH+2 clocks.
module bcd_convert_sched #(
  parameter int unsigned WIDTH = 8
) (
  input logic               clk,
  input logic               reset_n,
  bcd_convert_sched_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam int unsigned RegW = 12 + WIDTH;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e          r_state;
  logic [CntW-1:0] r_count;
  logic [RegW-1:0] r_work;
  logic            r_last_id;
  logic            r_cur_id;
  logic            r_done;
  logic            r_done_id;
  logic [3:0]      r_digit0;
  logic [3:0]      r_digit1;
  logic [3:0]      r_digit2;

  logic            w_grant0;
  logic            w_grant1;
  logic [11:0]     w_bcd_adj;
  logic [RegW-1:0] w_work_shift;

  // Grants are gated by reset so no ack can leak out while reset is held.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (reset_n && (r_state == StIdle)) begin
      w_grant0 = bus.req0 && (!bus.req1 || r_last_id);
      w_grant1 = bus.req1 && (!bus.req0 || !r_last_id);
    end
  end

  always_comb begin
    w_bcd_adj = r_work[RegW-1:WIDTH];
    for (int i = 0; i < 3; i++) begin
      if (w_bcd_adj[4*i +: 4] >= 4'd5) begin
        w_bcd_adj[4*i +: 4] = w_bcd_adj[4*i +: 4] + 4'd3;
      end
    end
    // The hundreds nibble never reaches bit 11 for WIDTH <= 9, so it is dropped.
    w_work_shift = RegW'({w_bcd_adj, r_work[WIDTH-1:0], 1'b0});
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= StIdle;
      r_count   <= '0;
      r_work    <= '0;
      r_last_id <= 1'b1;
      r_cur_id  <= 1'b0;
      r_done    <= 1'b0;
      r_done_id <= 1'b0;
      r_digit0  <= 4'd0;
      r_digit1  <= 4'd0;
      r_digit2  <= 4'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_grant0 || w_grant1) begin
            r_work    <= {12'd0, (w_grant1 ? bus.bin1 : bus.bin0)};
            r_cur_id  <= w_grant1;
            r_last_id <= w_grant1;
            r_count   <= CntW'(WIDTH);
            r_state   <= StShift;
          end
        end
        StShift: begin
          r_work  <= w_work_shift;
          r_count <= r_count - CntW'(1);
          if (r_count == CntW'(1)) begin
            r_digit2  <= w_work_shift[RegW-1 -: 4];
            r_digit1  <= w_work_shift[RegW-5 -: 4];
            r_digit0  <= w_work_shift[RegW-9 -: 4];
            r_done    <= 1'b1;
            r_done_id <= r_cur_id;
            r_state   <= StDone;
          end
        end
        StDone: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign bus.ack0    = w_grant0;
  assign bus.ack1    = w_grant1;
  assign bus.busy    = (r_state != StIdle) || w_grant0 || w_grant1;
  assign bus.done    = r_done;
  assign bus.done_id = r_done_id;
  assign bus.digit0  = r_digit0;
  assign bus.digit1  = r_digit1;
  assign bus.digit2  = r_digit2;

endmodule

// File: tb/tb_bcd_convert_sched.sv
// Bench for bcd_convert_sched: directed handshake/arbitration sequences, a vector
// table and an exhaustive sweep checked through a result scoreboard, plus a WIDTH=9 build.
module tb_bcd_convert_sched;

  logic clk;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc_n  = 0;
  int   n_done = 0;
  int   t_done = -1;
  int   done_hist[$];

  typedef struct {
    bit id;
    int d2;
    int d1;
    int d0;
  } exp_t;

  typedef struct {
    bit id;
    int bin;
    int d2;
    int d1;
    int d0;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[10];

  bcd_convert_sched_if #(.WIDTH(8)) bus ();
  bcd_convert_sched_if #(.WIDTH(9)) bus9 ();

  bcd_convert_sched #(.WIDTH(8)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  bcd_convert_sched #(.WIDTH(9)) u_dut9 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus9)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_n++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input bit id, input int b);
    exp_t e;
    e.id = id;
    e.d2 = b / 100;
    e.d1 = (b / 10) % 10;
    e.d0 = b % 10;
    return e;
  endfunction

  function automatic int dig8();
    return int'({bus.digit2, bus.digit1, bus.digit0});
  endfunction

  function automatic int bcd_of(input int b);
    return ((b / 100) << 8) | (((b / 10) % 10) << 4) | (b % 10);
  endfunction

  // Scoreboard: every done of the WIDTH=8 DUT must match the oldest expected result.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && bus.done) begin
      n_done++;
      t_done = cyc_n;
      done_hist.push_back(cyc_n);
      if (sb.size() == 0) begin
        check("unexpected done", 1, 0);
      end else begin
        e = sb.pop_front();
        check("sb done_id", int'(bus.done_id), int'(e.id));
        check("sb digit2", int'(bus.digit2), e.d2);
        check("sb digit1", int'(bus.digit1), e.d1);
        check("sb digit0", int'(bus.digit0), e.d0);
      end
    end
  end

  // Called at posedge+1; returns at the negedge of the ack cycle.
  task automatic wait_ack(input bit id, output int t);
    bit got;
    got = 1'b0;
    t   = -1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (id ? bus.ack1 : bus.ack0) begin
        got = 1'b1;
        t   = cyc_n;
        check("busy in ack cycle", int'(bus.busy), 1);
      end else begin
        @(posedge clk);
        #1;
      end
    end
    check("ack seen", int'(got), 1);
  endtask

  task automatic req_and_wait(input bit id, input int b, output int t);
    if (id) begin
      bus.req1 = 1'b1;
      bus.bin1 = 8'(b);
    end else begin
      bus.req0 = 1'b1;
      bus.bin0 = 8'(b);
    end
    wait_ack(id, t);
    @(posedge clk);
    #1;
    if (id) bus.req1 = 1'b0;
    else    bus.req0 = 1'b0;
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 40 && n_done < target; i++) @(posedge clk);
    #1;
    check("done count", n_done, target);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check("reset ack0", int'(bus.ack0), 0);
    check("reset busy", int'(bus.busy), 0);
    check("reset done", int'(bus.done), 0);
    check("reset digits", dig8(), 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic conv9(input bit id, input int b);
    bit got;
    bit got2;
    int t;
    int td;
    got  = 1'b0;
    got2 = 1'b0;
    t    = -1;
    td   = -100;
    if (id) begin
      bus9.req1 = 1'b1;
      bus9.bin1 = 9'(b);
    end else begin
      bus9.req0 = 1'b1;
      bus9.bin0 = 9'(b);
    end
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (id ? bus9.ack1 : bus9.ack0) begin
        got = 1'b1;
        t   = cyc_n;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    @(posedge clk);
    #1;
    bus9.req0 = 1'b0;
    bus9.req1 = 1'b0;
    for (int i = 0; i < 30 && !got2; i++) begin
      @(negedge clk);
      if (bus9.done) begin
        got2 = 1'b1;
        td   = cyc_n;
      end else begin
        @(posedge clk);
      end
    end
    check("w9 latency", td - t, 10);
    check("w9 done_id", int'(bus9.done_id), int'(id));
    check("w9 digits", int'({bus9.digit2, bus9.digit1, bus9.digit0}), bcd_of(b));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int t;
    int t0;
    int t1;
    int k;
    int base;
    bit got;
    bit exp_ids[4];

    tbl[0] = '{0, 243, 2, 4, 3};
    tbl[1] = '{1,   0, 0, 0, 0};
    tbl[2] = '{0, 255, 2, 5, 5};
    tbl[3] = '{1,   1, 0, 0, 1};
    tbl[4] = '{0,   9, 0, 0, 9};
    tbl[5] = '{1,  10, 0, 1, 0};
    tbl[6] = '{0,  99, 0, 9, 9};
    tbl[7] = '{1, 100, 1, 0, 0};
    tbl[8] = '{0, 128, 1, 2, 8};
    tbl[9] = '{1, 199, 1, 9, 9};

    // Reset held from time zero with random requests: outputs low before any edge.
    reset_n   = 1'b0;
    bus.req0  = 1'b1;
    bus.req1  = 1'b1;
    bus.bin0  = 8'($urandom);
    bus.bin1  = 8'($urandom);
    bus9.req0 = 1'b0;
    bus9.req1 = 1'b0;
    bus9.bin0 = '0;
    bus9.bin1 = '0;
    #2;
    check("por ack0", int'(bus.ack0), 0);
    check("por ack1", int'(bus.ack1), 0);
    check("por busy", int'(bus.busy), 0);
    check("por done", int'(bus.done), 0);
    check("por done_id", int'(bus.done_id), 0);
    check("por digits", dig8(), 0);
    repeat (2) @(posedge clk);
    #1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    reset_n  = 1'b1;
    @(posedge clk);
    #1;

    // Single request: busy over T..T+9, one-cycle done at T+9.
    req_and_wait(0, 243, t);
    sb.push_back(mk(0, 243));
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      check($sformatf("single busy T+%0d", j), int'(bus.busy), int'(j <= 9));
      check($sformatf("single done T+%0d", j), int'(bus.done), int'(j == 9));
      if (j < 10) begin
        @(posedge clk);
        #1;
      end
    end
    check("single latency", t_done - t, 9);
    @(posedge clk);
    #1;

    // Tie from reset: requester 0 first, then strict alternation.
    do_reset();
    base       = n_done;
    exp_ids    = '{0, 1, 0, 1};
    bus.req0   = 1'b1;
    bus.bin0   = 8'd255;
    bus.req1   = 1'b1;
    bus.bin1   = 8'd7;
    sb.push_back(mk(0, 255));
    sb.push_back(mk(1, 7));
    sb.push_back(mk(0, 255));
    sb.push_back(mk(1, 7));
    k = 0;
    for (int i = 0; i < 80 && k < 4; i++) begin
      @(negedge clk);
      if (bus.ack0 || bus.ack1) begin
        check($sformatf("tie grant %0d id", k), int'(bus.ack1), int'(exp_ids[k]));
        check($sformatf("tie grant %0d single", k), int'(bus.ack0 && bus.ack1), 0);
        k++;
      end
      @(posedge clk);
      #1;
      if (k == 4) begin
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
      end
    end
    check("tie grants seen", k, 4);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    wait_done(base + 4);
    check("tie done spacing",
          done_hist[done_hist.size()-1] - done_hist[done_hist.size()-2], 10);

    // Late request arriving mid-SHIFT waits for the next IDLE.
    base = n_done;
    req_and_wait(0, 50, t0);
    sb.push_back(mk(0, 50));
    repeat (2) @(posedge clk);
    #1;
    bus.req1 = 1'b1;
    bus.bin1 = 8'd100;
    got = 1'b0;
    t1  = -1;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (bus.ack1) begin
        got = 1'b1;
        t1  = cyc_n;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    check("late ack1 cycle", t1 - t0, 10);
    @(posedge clk);
    #1;
    bus.req1 = 1'b0;
    sb.push_back(mk(1, 100));
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      check($sformatf("late held digits T+%0d", j), dig8(), 12'h050);
      @(posedge clk);
      #1;
    end
    wait_done(base + 2);

    // Reset in the 4th SHIFT cycle abandons the conversion.
    bus.req0 = 1'b1;
    bus.bin0 = 8'd99;
    wait_ack(0, t);
    repeat (4) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("midrst done", int'(bus.done), 0);
    check("midrst busy", int'(bus.busy), 0);
    check("midrst digits", dig8(), 0);
    sb.delete();
    base = n_done;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("midrst regrant ack0", int'(bus.ack0), 1);
    t = cyc_n;
    @(posedge clk);
    #1;
    bus.req0 = 1'b0;
    sb.push_back(mk(0, 99));
    wait_done(base + 1);
    check("midrst latency", t_done - t, 9);

    // Vector table.
    for (int i = 0; i < 10; i++) begin
      base = n_done;
      req_and_wait(tbl[i].id, tbl[i].bin, t);
      sb.push_back('{tbl[i].id, tbl[i].d2, tbl[i].d1, tbl[i].d0});
      wait_done(base + 1);
      check($sformatf("vec %0d latency", i), t_done - t, 9);
    end

    // Exhaustive sweep, alternating requesters.
    for (int v = 0; v < 256; v++) begin
      base = n_done;
      req_and_wait(bit'(v % 2), v, t);
      sb.push_back(mk(bit'(v % 2), v));
      wait_done(base + 1);
    end
    check("scoreboard drained", sb.size(), 0);

    // WIDTH=9 build: max operand first, then the full range.
    conv9(1, 511);
    for (int v = 0; v < 512; v++) conv9(bit'(v % 2), v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_convert_sched.md
Name: bcd_convert_sched

Overview:
- Shared, iterative binary-to-BCD converter with a two-requester round-robin arbiter and a req/ack handshake.
- Time-shares one shift-add-3 (double-dabble) datapath between two score sources, e.g. player die total and running score.
- Delivers three registered decimal digits, tagged with the requester ID, to the seven-segment display logic.
- Converts one request per WIDTH+2 clocks.

Parameters:
- WIDTH, 8, binary operand width. Legal range 1..9, so the result always fits in three BCD digits (max 511).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req0  input  1  requester 0 conversion request. Held until ack0.
- bin0  input  WIDTH  requester 0 operand. Stable while req0 is high.
- ack0  output  1  one-cycle grant. bin0 is captured on the edge ending this cycle.
- req1  input  1  requester 1 conversion request.
- bin1  input  WIDTH  requester 1 operand.
- ack1  output  1  one-cycle grant for requester 1.
- busy  output  1  high from the ack cycle through the DONE cycle.
- done  output  1  one-cycle pulse: result valid.
- done_id  output  1  requester served by the current or last result.
- digit0  output  4  ones digit, registered, held until the next done.
- digit1  output  4  tens digit.
- digit2  output  4  hundreds digit.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - State=IDLE.
  - ack0, ack1, busy, done, done_id, digit0..2 = 0.
  - Shift counter and working register cleared.
  - last_id=1, so requester 0 wins the first tie.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - No request: stay in IDLE, busy=0.
  - Only reqN high: ackN=1 (combinational from state and req) and busy=1 in this cycle.
  - Both high: grant the requester != last_id.
  - On the clock edge: capture binN into the working register with BCD field cleared, set cur_id=N, last_id=N, count=WIDTH, go to SHIFT.
- SHIFT, each cycle:
  - Every BCD nibble >=5 gets +3.
  - Then the whole {BCD, binary} register shifts left by 1.
  - count decrements. After exactly WIDTH shifts, go to DONE.
  - Requests are ignored; no ack is issued.
- DONE, lasting one cycle:
  - done=1, done_id=cur_id.
  - digit2/1/0 show the final BCD nibbles. They are loaded on the edge entering DONE, so they are valid while done=1.
  - No grant in DONE. Next cycle: IDLE.
- Latency: ack cycle = T. SHIFT occupies T+1..T+WIDTH. done is high in cycle T+WIDTH+1. The earliest next ack is T+WIDTH+2.
- digit0..2 and done_id change only on entry to DONE. Between results they hold their values.
- Handshake:
  - A requester may drop req only after its ack.
  - A req still high after ack is a new request. It is eligible in the next IDLE and arbitrated normally.
  - A req that rises during SHIFT or DONE waits and is never lost.
  - A req dropped before ack is withdrawn with no side effect.
- Fairness: with both requesters continuously asserting, grants strictly alternate 0,1,0,1...
- Arithmetic:
  - Each nibble is 4 bits. After add-3 a nibble never exceeds 12 before the shift, so no overflow.
  - Each output digit is 0..9 for all legal WIDTH.
- Reset during SHIFT or DONE:
  - Conversion is abandoned immediately; no done pulse.
  - Digits return to 0.
  - The requester must re-request; its req, if still high, is granted after reset release.
- Clock-edge release of reset with req high: grant occurs in the first IDLE cycle after release.

Test Plan:
- Reset: drive reset_n=0 with random inputs. Required: ack0/1, busy, done, done_id, digit0..2 all 0, asynchronously, without a clock edge.
- Single request: req0=1, bin0=243 (WIDTH=8).
  - ack0 in cycle T.
  - done in cycle T+9 with done_id=0, digit2/1/0=2/4/3.
  - busy high T..T+9, low at T+10.
- Tie then alternation: req0=1, bin0=255 and req1=1, bin1=7, held continuously.
  - First result: done_id=0, digits 2/5/5.
  - Second result: done_id=1, digits 0/0/7, exactly 10 cycles later.
  - Grants continue alternating 0,1,0,1.
- Late request: req1 rises mid-SHIFT of a req0 conversion with bin1=100.
  - No ack1 until the cycle after done.
  - Then result done_id=1, digits 1/0/0.
  - The previous digits are held unchanged until that done.
- Reset mid-op: assert reset_n=0 in the 4th SHIFT cycle of bin0=99.
  - No done pulse.
  - Digits read 0.
  - After release with req0 still high: fresh ack0 and a correct 0/9/9 result 9 cycles later.
- Edge values and parameter: bin0=0 gives 0/0/0.
  - WIDTH=9 build with bin1=511: done at T+10, digits 5/1/1.
  - Exhaustive sweep 0..2^WIDTH-1 matches decimal digits for WIDTH=8 and WIDTH=9.
